// File: rtl/cq_pkg.sv
// ---------------------------------------------------------------------------
// cq_pkg
// Shared helpers for the parametrised circular queue (param_cq):
//   log2_depth() - address width AW for a given DEPTH
//   ptr_width()  - pointer width AW+1 (address bits plus one wrap bit)
//   is_pow2()    - DEPTH legality test (power of two, at least 2)
//   af_level_ok()/ae_level_ok() - flag threshold range tests
// The range tests are evaluated at elaboration time by param_cq.
// ---------------------------------------------------------------------------
package cq_pkg;

    // Smallest r with 2**r >= depth.
    function automatic int log2_depth(input int depth);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < depth) r = i + 1;
        end
        return r;
    endfunction

    // Pointer width: address bits plus the wrap bit that tells full from empty.
    function automatic int ptr_width(input int depth);
        return log2_depth(depth) + 1;
    endfunction

    function automatic bit is_pow2(input int n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

    function automatic bit af_level_ok(input int af_level, input int depth);
        return (af_level >= 1) && (af_level <= depth);
    endfunction

    function automatic bit ae_level_ok(input int ae_level, input int depth);
        return (ae_level >= 0) && (ae_level <= depth - 1);
    endfunction

endpackage

// File: rtl/param_cq_if.sv
// ---------------------------------------------------------------------------
// param_cq_if
// Producer/consumer side of the circular queue.
//   master : drives flush, wr, din, rd; observes data and status
//   slave  : the queue itself
// Signals:
//   flush        synchronous clear of queue state
//   wr / din     write request and data
//   rd           pop the entry currently on dout
//   dout         head entry (0 when empty)
//   empty, full, almost_empty, almost_full, count   occupancy status
//   overflow, underflow                             sticky error flags
// ---------------------------------------------------------------------------
interface param_cq_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
);
    localparam int PW = cq_pkg::ptr_width(DEPTH);

    logic             flush;
    logic             wr;
    logic [WIDTH-1:0] din;
    logic             rd;
    logic [WIDTH-1:0] dout;
    logic             empty;
    logic             full;
    logic             almost_empty;
    logic             almost_full;
    logic [PW-1:0]    count;
    logic             overflow;
    logic             underflow;

    modport master (
        output flush, wr, din, rd,
        input  dout, empty, full, almost_empty, almost_full, count,
               overflow, underflow
    );

    modport slave (
        input  flush, wr, din, rd,
        output dout, empty, full, almost_empty, almost_full, count,
               overflow, underflow
    );

endinterface

// File: rtl/cq_ptr.sv
// ---------------------------------------------------------------------------
// cq_ptr
// Queue pointer register: PW bits (AW address bits + wrap bit).
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset, clears the pointer
//   clr    synchronous clear, has priority over inc
//   inc    advance the pointer by one (wraps naturally modulo 2**PW)
//   ptr    current pointer value
// ---------------------------------------------------------------------------
module cq_ptr #(
    parameter int PW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          inc,
    output logic [PW-1:0] ptr
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + PW'(1);
        end
    end

endmodule

// File: rtl/param_cq.sv
// ---------------------------------------------------------------------------
// param_cq
// Circular FIFO queue, WIDTH-bit entries, DEPTH slots, show-ahead read port.
// Every slot is usable: each pointer carries a wrap bit, so equal pointers
// mean empty and equal addresses with differing wrap bits mean full.
// Ports:
//   clk    sole clock, rising edge
//   reset  asynchronous active-low reset (pointers and error flags)
//   bus    param_cq_if.slave: flush, wr/din, rd, dout, status and error flags
// All outputs are decoded from registered state only.
// ---------------------------------------------------------------------------
module param_cq
    import cq_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = 6,
    parameter int AE_LEVEL = 1
) (
    input  logic       clk,
    input  logic       reset,
    param_cq_if.slave  bus
);

    localparam int AW = log2_depth(DEPTH);
    localparam int PW = AW + 1;

    localparam logic [PW-1:0] AF_CNT = PW'(AF_LEVEL);
    localparam logic [PW-1:0] AE_CNT = PW'(AE_LEVEL);

    // Elaboration-time parameter legality.
    if (!is_pow2(DEPTH)) begin : g_bad_depth
        $error("param_cq: DEPTH must be a power of two >= 2");
    end
    if (!af_level_ok(AF_LEVEL, DEPTH)) begin : g_bad_af
        $error("param_cq: AF_LEVEL must be in 1..DEPTH");
    end
    if (!ae_level_ok(AE_LEVEL, DEPTH)) begin : g_bad_ae
        $error("param_cq: AE_LEVEL must be in 0..DEPTH-1");
    end

    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_addr;
    logic [AW-1:0]    wr_addr;
    logic [PW-1:0]    count_w;
    logic             empty_w;
    logic             full_w;
    logic             wr_acc;
    logic             rd_acc;
    logic             wr_err;
    logic             rd_err;
    logic             overflow_q;
    logic             underflow_q;
    logic [WIDTH-1:0] mem [DEPTH];

    assign rd_addr = rd_ptr[AW-1:0];
    assign wr_addr = wr_ptr[AW-1:0];

    assign count_w = wr_ptr - rd_ptr;
    assign empty_w = (wr_ptr == rd_ptr);
    assign full_w  = (wr_addr == rd_addr) && (wr_ptr[AW] != rd_ptr[AW]);

    // A write into a full queue is fine when the head is popped on the same
    // edge: the slot being overwritten is the one leaving. No bypass exists
    // for the empty case, so a read of an empty queue is always rejected.
    assign wr_acc = bus.wr & (~full_w | bus.rd);
    assign rd_acc = bus.rd & ~empty_w;
    assign wr_err = bus.wr & full_w & ~bus.rd;
    assign rd_err = bus.rd & empty_w;

    // Pointers: flush (clr) wins over any accepted access.
    cq_ptr #(.PW(PW)) u_rd_ptr (
        .clk   (clk),
        .reset (reset),
        .clr   (bus.flush),
        .inc   (rd_acc),
        .ptr   (rd_ptr)
    );

    cq_ptr #(.PW(PW)) u_wr_ptr (
        .clk   (clk),
        .reset (reset),
        .clr   (bus.flush),
        .inc   (wr_acc),
        .ptr   (wr_ptr)
    );

    // Storage is not reset; stale contents are masked by the pointers.
    always_ff @(posedge clk) begin
        if (!bus.flush && wr_acc) begin
            mem[wr_addr] <= bus.din;
        end
    end

    // Sticky error flags, cleared only by reset or flush.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (bus.flush) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_err) overflow_q  <= 1'b1;
            if (rd_err) underflow_q <= 1'b1;
        end
    end

    assign bus.dout         = empty_w ? '0 : mem[rd_addr];
    assign bus.empty        = empty_w;
    assign bus.full         = full_w;
    assign bus.count        = count_w;
    assign bus.almost_empty = (count_w <= AE_CNT);
    assign bus.almost_full  = (count_w >= AF_CNT);
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

endmodule
